// File: rtl/imm_decode_stage.sv
// Immediate-decode pipeline stage: classifies a fetched instruction, forms its
// extended immediate and holds results in a two-entry skid buffer.
module imm_decode_stage #(
    parameter int XLEN = 32,
    parameter bit RV64 = (XLEN == 64)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_immsrc,
    output logic            out_illegal
);

    localparam logic [2:0] FMT_I    = 3'b000;
    localparam logic [2:0] FMT_S    = 3'b001;
    localparam logic [2:0] FMT_B    = 3'b010;
    localparam logic [2:0] FMT_J    = 3'b011;
    localparam logic [2:0] FMT_U    = 3'b100;
    localparam logic [2:0] FMT_Z    = 3'b101;
    localparam logic [2:0] FMT_SH   = 3'b110;
    localparam logic [2:0] FMT_NONE = 3'b111;

    // Entry layout: {illegal, immsrc, imm, pc, instr}
    localparam int EW = 1 + 3 + XLEN + XLEN + 32;

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        is_shift;
    logic        sh_word;
    logic [2:0]  dec_src;
    logic        dec_ill;
    logic [63:0] imm64;
    logic [EW-1:0] dec_entry;

    assign opc      = in_instr[6:0];
    assign f3       = in_instr[14:12];
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    always_comb begin
        dec_src = FMT_NONE;
        dec_ill = 1'b0;
        sh_word = 1'b0;
        case (opc)
            7'b0000011, 7'b1100111: dec_src = FMT_I;
            7'b0010011: begin
                if (is_shift) begin
                    dec_src = FMT_SH;
                    // RV32 shamt is 5 bits; the immediate is still formed
                    dec_ill = !RV64 && in_instr[25];
                end else begin
                    dec_src = FMT_I;
                end
            end
            7'b0100011: dec_src = FMT_S;
            7'b1100011: dec_src = FMT_B;
            7'b1101111: dec_src = FMT_J;
            7'b0110111, 7'b0010111: dec_src = FMT_U;
            7'b1110011: dec_src = f3[2] ? FMT_Z : FMT_NONE;
            7'b0110011, 7'b0001111: dec_src = FMT_NONE;
            7'b0011011: begin
                if (RV64) begin
                    sh_word = is_shift;
                    dec_src = is_shift ? FMT_SH : FMT_I;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            7'b0111011: dec_ill = !RV64;
            default: dec_ill = 1'b1;
        endcase
    end

    // Build at 64 bits and truncate so one expression serves both XLENs
    always_comb begin
        imm64 = 64'd0;
        case (dec_src)
            FMT_I: imm64 = {{52{in_instr[31]}}, in_instr[31:20]};
            FMT_S: imm64 = {{52{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B: imm64 = {{51{in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_J: imm64 = {{43{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
            FMT_U: imm64 = {{32{in_instr[31]}}, in_instr[31:12], 12'd0};
            FMT_Z: imm64 = {59'd0, in_instr[19:15]};
            FMT_SH: begin
                if (RV64 && !sh_word)
                    imm64 = {58'd0, in_instr[25:20]};
                else
                    imm64 = {59'd0, in_instr[24:20]};
            end
            default: imm64 = 64'd0;
        endcase
    end

    assign dec_entry = {dec_ill, dec_src, imm64[XLEN-1:0], in_pc, in_instr};

    logic [1:0]    cnt_q, cnt_d;
    logic          in_ready_q, in_ready_d;
    logic [EW-1:0] ent0_q, ent0_d;
    logic [EW-1:0] ent1_q, ent1_d;
    logic          accept;
    logic          consume;

    assign accept  = in_valid && in_ready_q;
    assign consume = (cnt_q != 2'd0) && out_ready;

    always_comb begin
        cnt_d  = cnt_q;
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        if (flush) begin
            cnt_d = 2'd0;
        end else begin
            case (cnt_q)
                2'd0: begin
                    if (accept) begin
                        ent0_d = dec_entry;
                        cnt_d  = 2'd1;
                    end
                end
                2'd1: begin
                    case ({accept, consume})
                        2'b11: ent0_d = dec_entry;
                        2'b10: begin
                            ent1_d = dec_entry;
                            cnt_d  = 2'd2;
                        end
                        2'b01: cnt_d = 2'd0;
                        default: cnt_d = 2'd1;
                    endcase
                end
                2'd2: begin
                    // in_ready is low when full, so no accept can coincide
                    if (consume) begin
                        ent0_d = ent1_q;
                        cnt_d  = 2'd1;
                    end
                end
                default: cnt_d = 2'd0;
            endcase
        end
        in_ready_d = (cnt_d != 2'd2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= 2'd0;
            in_ready_q <= 1'b0;
            ent0_q     <= '0;
            ent1_q     <= '0;
        end else begin
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (cnt_q != 2'd0);
    assign out_instr   = ent0_q[31:0];
    assign out_pc      = ent0_q[32 +: XLEN];
    assign out_imm     = ent0_q[32 + XLEN +: XLEN];
    assign out_immsrc  = ent0_q[32 + 2*XLEN +: 3];
    assign out_illegal = ent0_q[EW-1];

endmodule
